// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - default geometry/timing constants and row-select helpers for the dot matrix scanner
//
// Contents:
//   DEF_ROWS/DEF_COLS/DEF_DIV/DEF_BLANK : default parameter values
//   row_word_t                          : widest supported row-select word (callers truncate to ROWS)
//   blank_row()                         : all rows deselected (active-low drive, so all ones)
//   row_select(idx)                     : one-cold word with only row idx driven low
package dot_pkg;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_DIV   = 2000;
    localparam int DEF_BLANK = 16;

    // Row helpers are built at this width and cut down to ROWS by the caller.
    localparam int MAX_ROWS = 32;

    typedef logic [MAX_ROWS-1:0] row_word_t;

    function automatic row_word_t blank_row();
        return '1;
    endfunction

    function automatic row_word_t row_select(input int unsigned idx);
        return ~(row_word_t'(1) << idx);
    endfunction

endpackage

// File: rtl/row_scan_timer.sv
// rtl/row_scan_timer.sv - row slot divider and row index counter for the dot matrix scanner
//
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   en   : scan enable; while low, div and idx are held at 0
//   div  : position inside the current row slot, 0..DIV-1
//   idx  : current row, 0..ROWS-1
//   wrap : high during the last cycle of the last row slot of a frame (only while en)
module row_scan_timer
    import dot_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int DIV  = DEF_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic [$clog2(DIV)-1:0]  div,
    output logic [$clog2(ROWS)-1:0] idx,
    output logic                    wrap
);

    localparam int DW = $clog2(DIV);
    localparam int IW = $clog2(ROWS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0] ROW_LAST = IW'(ROWS - 1);

    logic slot_end;

    assign slot_end = (div == DIV_LAST);
    assign wrap     = en && slot_end && (idx == ROW_LAST);

    // Dropping en parks the counters at 0 so the next enable starts a fresh
    // frame with the blanking interval of row 0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div <= '0;
            idx <= '0;
        end else if (slot_end) begin
            div <= '0;
            idx <= (idx == ROW_LAST) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/dot_matrix_scan.sv
// rtl/dot_matrix_scan.sv - double-buffered bi-colour LED dot matrix row scanner
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   en         : scan enable
//   wr_en      : back-buffer row write strobe
//   wr_row     : row written by wr_en (values >= ROWS ignored)
//   wr_r/wr_g  : red/green column bits for wr_row
//   swap_req   : request a front/back buffer swap at the next frame wrap
//   swap_ack   : one-cycle pulse when the swap is performed
//   frame_done : one-cycle pulse at frame wrap
//   led_r/led_g: registered column drive, active high
//   row        : registered row select, active low, one-cold
module dot_matrix_scan
    import dot_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int DIV   = DEF_DIV,
    parameter int BLANK = DEF_BLANK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_r,
    input  logic [COLS-1:0]         wr_g,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_done,
    output logic [COLS-1:0]         led_r,
    output logic [COLS-1:0]         led_g,
    output logic [ROWS-1:0]         row
);

    localparam int IW = $clog2(ROWS);
    localparam int DW = $clog2(DIV);

    localparam logic [IW:0]   ROWS_EXT = (IW + 1)'(ROWS);
    localparam logic [DW-1:0] BLANK_W  = DW'(BLANK);

    // One stored row: red in the upper half, green in the lower half.
    typedef logic [2*COLS-1:0] pix_row_t;

    pix_row_t fb [2][ROWS];
    logic     front_sel;
    logic     pending;

    logic [DW-1:0] div;
    logic [IW-1:0] idx;
    logic          wrap;

    logic     swap_pend_eff;
    logic     do_swap;
    logic     lit;
    logic     wr_ok;
    pix_row_t front_row;

    row_scan_timer #(
        .ROWS (ROWS),
        .DIV  (DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .div  (div),
        .idx  (idx),
        .wrap (wrap)
    );

    always_comb begin
        // A request arriving on the wrap cycle counts as already pending.
        swap_pend_eff = pending | swap_req;
        // While scanning, swaps wait for the frame wrap so a frame is never
        // torn; while idle there is nothing on screen, so swap immediately.
        do_swap       = swap_pend_eff && (en ? wrap : 1'b1);
        lit           = en && (div >= BLANK_W);
        wr_ok         = wr_en && ({1'b0, wr_row} < ROWS_EXT);
        front_row     = fb[front_sel][idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                fb[0][r] <= '0;
                fb[1][r] <= '0;
            end
            front_sel  <= 1'b0;
            pending    <= 1'b0;
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;
            led_r      <= '0;
            led_g      <= '0;
            row        <= ROWS'(blank_row());
        end else begin
            // Uses the pre-swap front_sel, so a write on the swap edge lands
            // in the buffer that becomes visible.
            if (wr_ok) begin
                fb[~front_sel][wr_row] <= {wr_r, wr_g};
            end
            front_sel  <= front_sel ^ do_swap;
            pending    <= swap_pend_eff & ~do_swap;
            swap_ack   <= do_swap;
            frame_done <= wrap;
            if (lit) begin
                row   <= ROWS'(row_select(32'(idx)));
                led_r <= front_row[2*COLS-1:COLS];
                led_g <= front_row[COLS-1:0];
            end else begin
                row   <= ROWS'(blank_row());
                led_r <= '0;
                led_g <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dot_matrix_scan.sv
// tb/tb_dot_matrix_scan.sv - self-checking bench for dot_matrix_scan (ROWS=4, COLS=4, DIV=4, BLANK=1)
module tb_dot_matrix_scan;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = ROWS * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [3:0] wr_r;
    logic [3:0] wr_g;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_done;
    logic [3:0] led_r;
    logic [3:0] led_g;
    logic [3:0] row;

    always #5 clk = ~clk;

    dot_matrix_scan #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_r       (wr_r),
        .wr_g       (wr_g),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_done (frame_done),
        .led_r      (led_r),
        .led_g      (led_g),
        .row        (row)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the scan position is the number of enabled cycles
    // since the frame started; row and slot fall out of plain division.
    logic [3:0] m_r [2][ROWS];
    logic [3:0] m_g [2][ROWS];
    int         m_cnt;
    int         m_fs;
    bit         m_pend;
    bit         m_valid = 1'b0;
    logic [3:0] e_row, e_r, e_g;
    logic       e_ack, e_fd;

    always @(posedge clk) begin : model
        int pos, slot, r;
        bit wrap_ev, pe, sw;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < ROWS; i++) begin
                    m_r[b][i] = '0;
                    m_g[b][i] = '0;
                end
            m_cnt  = 0;
            m_fs   = 0;
            m_pend = 1'b0;
            e_row  = 4'hF;
            e_r    = '0;
            e_g    = '0;
            e_ack  = 1'b0;
            e_fd   = 1'b0;
        end else begin
            wrap_ev = 1'b0;
            e_row   = 4'hF;
            e_r     = '0;
            e_g     = '0;
            if (en) begin
                pos     = m_cnt % FRAME;
                r       = pos / DIV;
                slot    = pos % DIV;
                wrap_ev = (pos == FRAME - 1);
                if (slot >= BLANK) begin
                    e_row = 4'hF & ~(4'(1) << r);
                    e_r   = m_r[m_fs][r];
                    e_g   = m_g[m_fs][r];
                end
                m_cnt++;
            end else begin
                m_cnt = 0;
            end
            pe    = m_pend || swap_req;
            sw    = pe && (en ? wrap_ev : 1'b1);
            e_fd  = wrap_ev;
            e_ack = sw;
            if (wr_en && int'(wr_row) < ROWS) begin
                m_r[1-m_fs][wr_row] = wr_r;
                m_g[1-m_fs][wr_row] = wr_g;
            end
            if (sw) m_fs = 1 - m_fs;
            m_pend = pe && !sw;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_row",   32'(row),        32'(e_row));
            chk("m_led_r", 32'(led_r),      32'(e_r));
            chk("m_led_g", 32'(led_g),      32'(e_g));
            chk("m_ack",   32'(swap_ack),   32'(e_ack));
            chk("m_fd",    32'(frame_done), 32'(e_fd));
        end
    end

    // Directed stimulus with hand-computed expectations. k is the index of the
    // last enabled-scan edge whose outputs are now visible.
    int k;
    int ack_cnt = 0;
    int a0;
    logic [3:0] exp_rows [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                  4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    task automatic cyc();
        @(negedge clk);
        k++;
        if (swap_ack) ack_cnt++;
    endtask

    task automatic run_to(input int n);
        while (k < n) cyc();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_row = '0;
        wr_r = '0; wr_g = '0; swap_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row",   32'(row),        32'hF);
        chk("rst_led_r", 32'(led_r),      32'h0);
        chk("rst_led_g", 32'(led_g),      32'h0);
        chk("rst_ack",   32'(swap_ack),   32'h0);
        chk("rst_fd",    32'(frame_done), 32'h0);

        // Plain scan of an empty front buffer.
        rst = 1'b0; en = 1'b1; k = -1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("scan_row", 32'(row),        32'(exp_rows[i]));
            chk("scan_fd",  32'(frame_done), 32'(i == 15));
            chk("scan_led", 32'(led_r),      32'h0);
        end

        // Back-buffer write plus swap request mid-frame.
        wr_en = 1'b1; wr_row = 2'd2; wr_r = 4'b1010; wr_g = 4'b0101; swap_req = 1'b1;
        cyc();
        wr_en = 1'b0; swap_req = 1'b0;
        a0 = ack_cnt;
        run_to(25);
        chk("pre_swap_led_r", 32'(led_r), 32'h0);
        run_to(31);
        chk("swap1_ack", 32'(swap_ack),   32'h1);
        chk("swap1_fd",  32'(frame_done), 32'h1);
        run_to(41);
        chk("post_swap_led_r", 32'(led_r), 32'hA);
        chk("post_swap_led_g", 32'(led_g), 32'h5);
        run_to(47);
        chk("swap1_count", 32'(ack_cnt - a0), 32'h1);

        // Swap request and write on the wrap cycle itself.
        run_to(62);
        swap_req = 1'b1; wr_en = 1'b1; wr_row = 2'd0; wr_r = 4'b1111; wr_g = 4'b0000;
        cyc();
        chk("wrap_swap_ack", 32'(swap_ack),   32'h1);
        chk("wrap_swap_fd",  32'(frame_done), 32'h1);
        swap_req = 1'b0; wr_en = 1'b0;
        run_to(65);
        chk("wrap_wr_led_r", 32'(led_r), 32'hF);
        chk("wrap_wr_led_g", 32'(led_g), 32'h0);
        run_to(73);
        chk("wrap_row2_led_r", 32'(led_r), 32'h0);

        // Two requests in one frame give a single swap.
        run_to(69);
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        run_to(71);
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        a0 = ack_cnt;
        run_to(78);
        chk("dbl_no_early_ack", 32'(ack_cnt - a0), 32'h0);
        run_to(89);
        chk("dbl_led_r", 32'(led_r), 32'hA);
        run_to(95);
        chk("dbl_count", 32'(ack_cnt - a0), 32'h1);

        // Disable with a pending swap, then re-enable.
        run_to(96);
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        run_to(99);
        en = 1'b0;
        cyc();
        chk("dis_ack",   32'(swap_ack),   32'h1);
        chk("dis_row",   32'(row),        32'hF);
        chk("dis_led_r", 32'(led_r),      32'h0);
        chk("dis_fd",    32'(frame_done), 32'h0);
        repeat (3) cyc();
        chk("dis_ack_once", 32'(swap_ack), 32'h0);
        chk("dis_row_hold", 32'(row),      32'hF);
        en = 1'b1;
        cyc();
        chk("reen_blank", 32'(row), 32'hF);
        cyc();
        chk("reen_row0",  32'(row),   32'hE);
        chk("reen_led_r", 32'(led_r), 32'hF);

        // Reset mid-frame with a swap pending.
        run_to(107);
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        rst = 1'b1;
        cyc();
        chk("mid_rst_row",   32'(row),        32'hF);
        chk("mid_rst_led_r", 32'(led_r),      32'h0);
        chk("mid_rst_ack",   32'(swap_ack),   32'h0);
        chk("mid_rst_fd",    32'(frame_done), 32'h0);
        rst = 1'b0;
        a0 = ack_cnt;
        cyc();
        chk("post_rst_blank", 32'(row), 32'hF);
        cyc();
        chk("post_rst_row0",  32'(row),   32'hE);
        chk("post_rst_led_r", 32'(led_r), 32'h0);
        run_to(145);
        chk("post_rst_no_ack", 32'(ack_cnt - a0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_matrix_scan.md
DOT_MATRIX_SCAN -- requirements
Module: dot_matrix_scan

Interface
REQ-001 Parameter ROWS, default 8: number of multiplexed matrix rows (>=2).
REQ-002 Parameter COLS, default 8: columns per row, per colour (>=1).
REQ-003 Parameter DIV, default 2000: clk cycles per row slot (>=2).
REQ-004 Parameter BLANK, default 16: blanked cycles at the start of each row slot (0 <= BLANK < DIV).
REQ-005 Ports SHALL be:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- wr_en  in  1  back-buffer row write strobe.
- wr_row  in  clog2(ROWS)  target row; values >= ROWS are ignored.
- wr_r  in  COLS  red bits for wr_row.
- wr_g  in  COLS  green bits for wr_row.
- swap_req  in  1  request to swap front/back buffers.
- swap_ack  out  1  one-cycle pulse; swap performed.
- frame_done  out  1  one-cycle pulse at frame wrap.
- led_r  out  COLS  red column drive, active high.
- led_g  out  COLS  green column drive, active high.
- row  out  ROWS  row select, active low, one-cold.

Function
REQ-006 SHALL hold two ROWS x (2*COLS) frame buffers; front_sel selects the displayed one, the other is the back buffer.
REQ-007 A wr_en write SHALL update the back buffer row wr_row on the same edge; the front buffer is never writable.
REQ-008 Divider div SHALL count 0..DIV-1 and wrap; row index idx SHALL increment when div==DIV-1 and wrap ROWS-1 -> 0.
REQ-009 All outputs SHALL be registered; outputs at edge N+1 reflect div/idx/front_sel values at edge N (latency 1).
REQ-010 While div < BLANK: row = all ones, led_r = led_g = 0.
REQ-011 While div >= BLANK: row = all ones except bit idx = 0; led_r/led_g = front buffer row idx.
REQ-012 frame_done SHALL pulse for one cycle when div==DIV-1 and idx==ROWS-1 (wrap event).
REQ-013 swap_req SHALL set a pending flag; further swap_req while pending SHALL have no additional effect.
REQ-014 With en=1, a pending swap SHALL execute only at the wrap event: front_sel toggles, pending clears, swap_ack pulses the same cycle as frame_done.
REQ-015 swap_req coincident with the wrap event SHALL be honoured at that wrap.
REQ-016 wr_en coincident with a swap SHALL write the pre-swap back buffer, so the data is visible in the new front frame.
REQ-017 With en=0: div and idx held at 0, outputs blank (row all ones, leds 0), frame_done 0; a pending swap executes on the next edge with swap_ack pulse.
REQ-018 en rising SHALL start scanning from div=0, idx=0, beginning with the BLANK interval.

Reset
REQ-019 rst SHALL force div=0, idx=0, front_sel=0, pending=0, both buffers all zeros, row all ones, led_r=led_g=0, swap_ack=0, frame_done=0.
REQ-020 rst SHALL take priority over en, wr_en and swap_req in the same cycle; reset mid-frame discards any pending swap.

Structure
REQ-021 Package dot_pkg SHALL hold the default ROWS/COLS/DIV/BLANK constants and the blank-row constant function.
REQ-022 Divider and row counter SHALL live in sub-module row_scan_timer (outputs div, idx, wrap); buffers and output registers stay in dot_matrix_scan.

Verification (ROWS=4, COLS=4, DIV=4, BLANK=1)
REQ-023 Reset, en=1, no writes -> row steps 1110,1101,1011,0111 with one 1111 cycle before each, leds 0, frame_done every 16 cycles.
REQ-024 Write back row2 r=1010, g=0101, swap_req once -> swap_ack with first frame_done; next frame row2 slot shows led_r=1010, led_g=0101; front unchanged before swap.
REQ-025 swap_req on the wrap cycle plus wr_en row0 r=1111 same cycle -> swap that wrap; row0 slot of following frame shows led_r=1111.
REQ-026 Two swap_req mid-frame -> exactly one swap_ack at the next wrap; front_sel toggles once.
REQ-027 en=0 with pending swap -> swap_ack next cycle, outputs blank; en=1 -> blank cycle then row=1110.
REQ-028 rst asserted mid-frame with pending swap -> next cycle all outputs at reset values, buffers zero, no swap_ack afterwards.
